// File: rtl/ro_puf_controller.sv
// RO PUF measurement sequencer: for each ring-oscillator pair it clears, gates, settles
// and compares the two counters, building one response bit per pair.
module ro_puf_controller #(
  parameter int unsigned N_BITS     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WINDOW     = 4096,
  parameter int unsigned CLR_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 4,
  localparam int unsigned SEL_W     = $clog2(2 * N_BITS),
  localparam int unsigned TIE_W     = $clog2(N_BITS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [N_BITS-1:0] challenge_i,
  output logic [SEL_W-1:0]  sel_a_o,
  output logic [SEL_W-1:0]  sel_b_o,
  output logic              cnt_clr_o,
  output logic              cnt_en_o,
  input  logic [CNT_W-1:0]  cnt_a_i,
  input  logic [CNT_W-1:0]  cnt_b_i,
  input  logic              fin_a_i,
  input  logic              fin_b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              resp_valid_o,
  output logic [N_BITS-1:0] response_o,
  output logic [TIE_W-1:0]  tie_count_o
);

  localparam int unsigned IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int unsigned TMR_W = $clog2(WINDOW + CLR_CYC + SETTLE_CYC + 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StClear   = 3'd1;
  localparam logic [2:0] StCount   = 3'd2;
  localparam logic [2:0] StSettle  = 3'd3;
  localparam logic [2:0] StCompare = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_BITS-1:0] chal_q, chal_d;
  logic [N_BITS-1:0] resp_q, resp_d;
  logic [TIE_W-1:0]  tie_q, tie_d;
  logic [SEL_W-1:0]  sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic              valid_q, valid_d, busy_q, busy_d;
  logic              clr_q, en_q, done_q;
  logic [1:0]        fin_a_sync_q, fin_b_sync_q;
  logic              fin_sync;

  assign fin_sync = fin_a_sync_q[1] | fin_b_sync_q[1];

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    chal_d  = chal_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          chal_d  = challenge_i;
          idx_d   = '0;
          resp_d  = '0;
          tie_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          tmr_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        if (tmr_q == TMR_W'(CLR_CYC - 1)) begin
          tmr_d   = '0;
          state_d = StCount;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      StCount: begin
        // Early stop: a counter reported overflow/finish, stop gating both.
        if (fin_sync || (tmr_q == TMR_W'(WINDOW - 1))) begin
          tmr_d   = '0;
          state_d = StSettle;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      StSettle: begin
        if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
          tmr_d   = '0;
          state_d = StCompare;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      StCompare: begin
        resp_d[idx_q] = (cnt_a_i > cnt_b_i);
        if (cnt_a_i == cnt_b_i) tie_d = tie_q + TIE_W'(1);
        if (idx_q == IDX_W'(N_BITS - 1)) begin
          valid_d = 1'b1;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StClear;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Route the next pair as CLEAR is entered so the mux is stable through COMPARE.
    if ((state_d == StClear) && (state_q != StClear)) begin
      sel_a_d = SEL_W'(2 * idx_d + chal_d[idx_d]);
      sel_b_d = SEL_W'(2 * idx_d + 1 - chal_d[idx_d]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      tmr_q        <= '0;
      idx_q        <= '0;
      chal_q       <= '0;
      resp_q       <= '0;
      tie_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      sel_a_q      <= '0;
      sel_b_q      <= '0;
      clr_q        <= 1'b0;
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      fin_a_sync_q <= '0;
      fin_b_sync_q <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      idx_q        <= idx_d;
      chal_q       <= chal_d;
      resp_q       <= resp_d;
      tie_q        <= tie_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      sel_a_q      <= sel_a_d;
      sel_b_q      <= sel_b_d;
      clr_q        <= (state_d == StClear);
      en_q         <= (state_d == StCount);
      done_q       <= (state_d == StDone);
      fin_a_sync_q <= {fin_a_sync_q[0], fin_a_i};
      fin_b_sync_q <= {fin_b_sync_q[0], fin_b_i};
    end
  end

  assign sel_a_o      = sel_a_q;
  assign sel_b_o      = sel_b_q;
  assign cnt_clr_o    = clr_q;
  assign cnt_en_o     = en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign resp_valid_o = valid_q;
  assign response_o   = resp_q;
  assign tie_count_o  = tie_q;

endmodule

// File: tb/tb_ro_puf_controller.sv
// Scoreboard bench for ro_puf_controller with a behavioural counter pair per RO.
module tb_ro_puf_controller;

  localparam int unsigned N_BITS = 8;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [N_BITS-1:0] challenge = '0;
  logic [3:0]        sel_a, sel_b;
  logic              cnt_clr, cnt_en;
  logic [CNT_W-1:0]  cnt_a = '0, cnt_b = '0;
  logic              fin_a = 1'b0, fin_b = 1'b0;
  logic              busy, done, resp_valid;
  logic [N_BITS-1:0] response;
  logic [3:0]        tie_count;

  logic [CNT_W-1:0]  ro_val [16];

  typedef struct packed {
    logic [7:0] resp;
    logic [3:0] tie;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ro_puf_controller #(
    .N_BITS    (8),
    .CNT_W     (16),
    .WINDOW    (16),
    .CLR_CYC   (4),
    .SETTLE_CYC(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .challenge_i (challenge),
    .sel_a_o     (sel_a),
    .sel_b_o     (sel_b),
    .cnt_clr_o   (cnt_clr),
    .cnt_en_o    (cnt_en),
    .cnt_a_i     (cnt_a),
    .cnt_b_i     (cnt_b),
    .fin_a_i     (fin_a),
    .fin_b_i     (fin_b),
    .busy_o      (busy),
    .done_o      (done),
    .resp_valid_o(resp_valid),
    .response_o  (response),
    .tie_count_o (tie_count)
  );

  // Counter model: cleared by CLR, reaches the routed RO's per-window count once enabled.
  always @(posedge clk) begin
    if (cnt_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (cnt_en) begin
      cnt_a <= ro_val[sel_a];
      cnt_b <= ro_val[sel_b];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cnt_clr && cnt_en) begin
        fails++;
        $display("FAIL clr_en_overlap: clr=%b en=%b expected never both", cnt_clr, cnt_en);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("response", 32'(response), 32'(e.resp));
          check("tie_count", 32'(tie_count), 32'(e.tie));
          check("resp_valid_at_done", 32'(resp_valid), 32'd1);
        end
      end
    end
  end

  task automatic set_ros(input logic [CNT_W-1:0] even_v, input logic [CNT_W-1:0] odd_v);
    for (int r = 0; r < 16; r++) ro_val[r] = (r % 2 == 0) ? even_v : odd_v;
  endtask

  // Cycle 1 is the IDLE cycle in which start is sampled.
  task automatic run(input logic [7:0] chal, input logic [7:0] exp_resp, input logic [3:0] exp_tie,
                     input int exp_lat, input bit poke, input bit early);
    int cyc, p, en_off, busy_bad;
    bit prev_clr;
    logic c;
    @(negedge clk);
    start = 1'b1;
    challenge = chal;
    sb.push_back('{resp: exp_resp, tie: exp_tie});
    cyc = 1; p = 0; en_off = 0; busy_bad = 0; prev_clr = 1'b0;
    while (cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        start = 1'b0;
        challenge = ~chal;
        check("resp_valid_cleared", 32'(resp_valid), 32'd0);
      end
      if (poke && cyc == 50) begin
        start = 1'b1;
        challenge = 8'hFF;
      end
      if (poke && cyc == 51) start = 1'b0;
      if (early && cyc == 10) begin
        check("en_before_fin", 32'(cnt_en), 32'd1);
        fin_a = 1'b1;
      end
      if (early && cyc == 14) fin_a = 1'b0;
      if (early && en_off == 0 && cyc > 10 && !cnt_en) en_off = cyc;
      if (cnt_clr && !prev_clr) begin
        c = chal[p];
        check("sel_a", 32'(sel_a), 32'(2 * p + int'(c)));
        check("sel_b", 32'(sel_b), 32'(2 * p + 1 - int'(c)));
        p++;
      end
      prev_clr = cnt_clr;
      if (!busy) busy_bad++;
      if (done) break;
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_latency", 32'(cyc), 32'(exp_lat));
    check("busy_throughout", 32'(busy_bad), 32'd0);
    check("pairs_measured", 32'(p), 32'd8);
    if (early) check("early_en_drop_by_cyc13", 32'(en_off >= 11 && en_off <= 13), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("resp_valid_holds", 32'(resp_valid), 32'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return {sel_a, sel_b, cnt_clr, cnt_en, busy, done, resp_valid, response, tie_count};
  endfunction

  initial begin
    int dones;
    set_ros(16'd100, 16'd90);
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'd0);

    // 1 + 8*(4+16+4+1) + 1 = 202
    run(8'h00, 8'hFF, 4'd0, 202, 1'b0, 1'b0);
    run(8'hA5, 8'h5A, 4'd0, 202, 1'b1, 1'b0);
    set_ros(16'd77, 16'd77);
    run(8'h3C, 8'h00, 4'd8, 202, 1'b0, 1'b0);
    // Pair 0 COUNT shrinks from 16 cycles (6..21) to 7 (6..12): 202 - 9
    set_ros(16'd100, 16'd90);
    run(8'h00, 8'hFF, 4'd0, 193, 1'b0, 1'b1);

    // Reset mid-COUNT aborts the measurement
    @(negedge clk);
    start = 1'b1;
    challenge = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_count_en", 32'(cnt_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("idle_after_abort", 32'(dones), 32'd0);
    check("outputs_after_abort", all_outs(), 64'd0);

    run(8'h3C, 8'hC3, 4'd0, 202, 1'b0, 1'b0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
